// File: rtl/deit_ctrl_pkg.sv
// deit_ctrl_pkg
// Shared definitions for the DeiT control slice.
//   - IDX_W_DEFAULT : default width of tile counts and tile indices
//   - sched_state_e : tile scheduler state encoding (IDLE..DONE = 0..4).
//                     The debug monitor decodes these same values, so the
//                     numbering must not be changed.
package deit_ctrl_pkg;

  localparam int IDX_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_DONE      = 3'd4
  } sched_state_e;

endpackage

// File: rtl/matmul_tile_scheduler_if.sv
// matmul_tile_scheduler_if
// Groups the scheduler's host, core and writeback signals.
//   Host      : ap_start, ap_done, ap_idle, cfg_m/n/k_tiles
//   Core      : core_start, core_done, tile_m/n/k_idx, tile_first_k, tile_last_k
//   Writeback : wb_valid, wb_ready, wb_m_idx, wb_n_idx
// Modports:
//   slave  - the scheduler itself
//   master - the surrounding system (host, core, writeback path)
interface matmul_tile_scheduler_if
  import deit_ctrl_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT
) ();

  logic             ap_start;
  logic             ap_done;
  logic             ap_idle;
  logic [IDX_W-1:0] cfg_m_tiles;
  logic [IDX_W-1:0] cfg_n_tiles;
  logic [IDX_W-1:0] cfg_k_tiles;

  logic             core_start;
  logic             core_done;
  logic [IDX_W-1:0] tile_m_idx;
  logic [IDX_W-1:0] tile_n_idx;
  logic [IDX_W-1:0] tile_k_idx;
  logic             tile_first_k;
  logic             tile_last_k;

  logic             wb_valid;
  logic             wb_ready;
  logic [IDX_W-1:0] wb_m_idx;
  logic [IDX_W-1:0] wb_n_idx;

  modport slave (
    input  ap_start, cfg_m_tiles, cfg_n_tiles, cfg_k_tiles, core_done, wb_ready,
    output ap_done, ap_idle, core_start, tile_m_idx, tile_n_idx, tile_k_idx,
           tile_first_k, tile_last_k, wb_valid, wb_m_idx, wb_n_idx
  );

  modport master (
    output ap_start, cfg_m_tiles, cfg_n_tiles, cfg_k_tiles, core_done, wb_ready,
    input  ap_done, ap_idle, core_start, tile_m_idx, tile_n_idx, tile_k_idx,
           tile_first_k, tile_last_k, wb_valid, wb_m_idx, wb_n_idx
  );

endinterface

// File: rtl/tile_idx_counter.sv
// tile_idx_counter
// Nested three-level wrap counter over (m, n, k), k innermost.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   clear                 - zero all three indices
//   inc_k                 - advance k by one
//   inc_n                 - finish the output tile: k <- 0, advance n, wrap into m
//   m/n/k_tiles           - latched tile counts
//   m/n/k_idx             - current indices
//   k_first, k_last       - k is 0 / k is k_tiles-1
//   n_last, m_last        - n is n_tiles-1 / m is m_tiles-1
module tile_idx_counter
  import deit_ctrl_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc_k,
  input  logic             inc_n,
  input  logic [IDX_W-1:0] m_tiles,
  input  logic [IDX_W-1:0] n_tiles,
  input  logic [IDX_W-1:0] k_tiles,
  output logic [IDX_W-1:0] m_idx,
  output logic [IDX_W-1:0] n_idx,
  output logic [IDX_W-1:0] k_idx,
  output logic             k_first,
  output logic             k_last,
  output logic             n_last,
  output logic             m_last
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  // Equality against count-1. A zero count never reaches this point in a
  // running job, so the all-ones result of 0-1 simply never matches and keeps
  // k_last low while idle after reset.
  assign k_first = (k_idx == '0);
  assign k_last  = (k_idx == k_tiles - ONE);
  assign n_last  = (n_idx == n_tiles - ONE);
  assign m_last  = (m_idx == m_tiles - ONE);

  // inc_n ends an output tile, so it also restarts the K reduction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx <= '0;
      n_idx <= '0;
      k_idx <= '0;
    end else if (clear) begin
      m_idx <= '0;
      n_idx <= '0;
      k_idx <= '0;
    end else if (inc_n) begin
      k_idx <= '0;
      if (n_last) begin
        n_idx <= '0;
        m_idx <= m_last ? '0 : m_idx + ONE;
      end else begin
        n_idx <= n_idx + ONE;
      end
    end else if (inc_k) begin
      k_idx <= k_idx + ONE;
    end
  end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler
// Steps the compute core through an M x N grid of output tiles, each reduced
// over K chunks, and hands every finished output tile to the writeback path.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus (slave)  - host ap_* / cfg_*, core start/done with tile indices and
//                  first/last-k flags, writeback valid/ready with tile indices
// Optional build macro TILE_SCHED_PERF_EN adds:
//   perf_busy_cycles     - cycles spent outside IDLE
//   perf_wb_stall_cycles - cycles with wb_valid high and wb_ready low
//   Both clear on an accepted ap_start and saturate at all-ones.
module matmul_tile_scheduler
  import deit_ctrl_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  matmul_tile_scheduler_if.slave  bus
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_busy_cycles,
  output logic [31:0]             perf_wb_stall_cycles
`endif
);

  sched_state_e     state_q;
  sched_state_e     state_d;

  logic [IDX_W-1:0] m_tiles_q;
  logic [IDX_W-1:0] n_tiles_q;
  logic [IDX_W-1:0] k_tiles_q;

  logic             accept;
  logic             cnt_clear;
  logic             inc_k;
  logic             inc_n;

  logic [IDX_W-1:0] m_idx;
  logic [IDX_W-1:0] n_idx;
  logic [IDX_W-1:0] k_idx;
  logic             k_first;
  logic             k_last;
  logic             n_last;
  logic             m_last;

  logic             any_zero_cfg;

  // A zero count on any axis means an empty job; it is judged on the raw
  // inputs because they are being latched on this same edge.
  assign any_zero_cfg = (bus.cfg_m_tiles == '0) || (bus.cfg_n_tiles == '0) ||
                        (bus.cfg_k_tiles == '0);

  tile_idx_counter #(
    .IDX_W (IDX_W)
  ) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .inc_k   (inc_k),
    .inc_n   (inc_n),
    .m_tiles (m_tiles_q),
    .n_tiles (n_tiles_q),
    .k_tiles (k_tiles_q),
    .m_idx   (m_idx),
    .n_idx   (n_idx),
    .k_idx   (k_idx),
    .k_first (k_first),
    .k_last  (k_last),
    .n_last  (n_last),
    .m_last  (m_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Configuration is captured only on an accepted start, so later cfg_*
  // changes cannot disturb a running job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tiles_q <= '0;
      n_tiles_q <= '0;
      k_tiles_q <= '0;
    end else if (accept) begin
      m_tiles_q <= bus.cfg_m_tiles;
      n_tiles_q <= bus.cfg_n_tiles;
      k_tiles_q <= bus.cfg_k_tiles;
    end
  end

  // core_done is only looked at in WAIT and ap_start only in IDLE, so stray
  // pulses in other states fall through the default hold.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    cnt_clear = 1'b0;
    inc_k     = 1'b0;
    inc_n     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ap_start) begin
          accept    = 1'b1;
          cnt_clear = 1'b1;
          state_d   = any_zero_cfg ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.core_done) begin
          if (k_last) begin
            state_d = ST_WRITEBACK;
          end else begin
            inc_k   = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_WRITEBACK: begin
        if (bus.wb_ready) begin
          inc_n   = 1'b1;
          state_d = (n_last && m_last) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ap_idle      = (state_q == ST_IDLE);
  assign bus.ap_done      = (state_q == ST_DONE);
  assign bus.core_start   = (state_q == ST_ISSUE);
  assign bus.wb_valid     = (state_q == ST_WRITEBACK);

  assign bus.tile_m_idx   = m_idx;
  assign bus.tile_n_idx   = n_idx;
  assign bus.tile_k_idx   = k_idx;
  assign bus.tile_first_k = k_first;
  assign bus.tile_last_k  = k_last;

  // The indices cannot move while WRITEBACK waits for ready, so the offered
  // tile is the current (m, n).
  assign bus.wb_m_idx     = m_idx;
  assign bus.wb_n_idx     = n_idx;

`ifdef TILE_SCHED_PERF_EN
  logic stall_now;

  assign stall_now = bus.wb_valid && !bus.wb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles     <= '0;
      perf_wb_stall_cycles <= '0;
    end else if (accept) begin
      perf_busy_cycles     <= '0;
      perf_wb_stall_cycles <= '0;
    end else begin
      if ((state_q != ST_IDLE) && (perf_busy_cycles != '1)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if (stall_now && (perf_wb_stall_cycles != '1)) begin
        perf_wb_stall_cycles <= perf_wb_stall_cycles + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
